// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one 8N1 UART transmit line between NUM_REQ byte producers.
// Bit timing comes from a clock-enable counter running on i_clk; no derived clocks.
module uart_tx_sched #(
    parameter int NUM_REQ      = 4,
    parameter int CLKS_PER_BIT = 2500
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [NUM_REQ-1:0]         i_req_valid,
    input  logic [8*NUM_REQ-1:0]       i_req_data,
    output logic [NUM_REQ-1:0]         o_req_ready,
    output logic                       o_tx,
    output logic                       o_busy,
    output logic [$clog2(NUM_REQ)-1:0] o_grant_id
);

    localparam int GW = $clog2(NUM_REQ);
    localparam int CW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_n;
    logic [GW-1:0] ptr, ptr_n, winner, grant_n, scan_g;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bidx, bidx_n;
    logic [7:0]    shift, shift_n;
    logic          tx_n, busy_n, found, bit_end, hs;
    logic [7:0]    req_byte [NUM_REQ];
    int            scan_idx;

    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            req_byte[k] = i_req_data[8*k +: 8];
        end
    end

    // Scan ptr, ptr+1, ... modulo NUM_REQ; the first asserted valid wins.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        scan_idx = 0;
        scan_g   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_idx = (int'(ptr) + i) % NUM_REQ;
            scan_g   = GW'(scan_idx);
            if (!found && i_req_valid[scan_g]) begin
                found  = 1'b1;
                winner = scan_g;
            end
        end
    end

    // Gating with i_rst keeps ready low for the whole time reset is held.
    assign hs      = (state == IDLE) && found && !i_rst;
    assign bit_end = (cnt == CW'(CLKS_PER_BIT - 1));

    always_comb begin
        o_req_ready = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            o_req_ready[k] = hs && (GW'(k) == winner);
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        cnt_n   = cnt;
        bidx_n  = bidx;
        shift_n = shift;
        tx_n    = o_tx;
        busy_n  = o_busy;
        grant_n = o_grant_id;
        if (state != IDLE) begin
            cnt_n = bit_end ? '0 : cnt + CW'(1);
        end
        case (state)
            IDLE: begin
                if (hs) begin
                    shift_n = req_byte[winner];
                    grant_n = winner;
                    ptr_n   = (winner == GW'(NUM_REQ - 1)) ? '0 : winner + GW'(1);
                    cnt_n   = '0;
                    busy_n  = 1'b1;
                    tx_n    = 1'b0;
                    state_n = START;
                end
            end
            START: begin
                if (bit_end) begin
                    tx_n    = shift[0];
                    bidx_n  = 3'd0;
                    state_n = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bidx != 3'd7) begin
                        shift_n = {1'b0, shift[7:1]};
                        tx_n    = shift[1];
                        bidx_n  = bidx + 3'd1;
                    end else begin
                        tx_n    = 1'b1;
                        state_n = STOP;
                    end
                end
            end
            STOP: begin
                tx_n = 1'b1;
                if (bit_end) begin
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= IDLE;
            ptr        <= '0;
            cnt        <= '0;
            bidx       <= 3'd0;
            shift      <= 8'd0;
            o_tx       <= 1'b1;
            o_busy     <= 1'b0;
            o_grant_id <= '0;
        end else begin
            state      <= state_n;
            ptr        <= ptr_n;
            cnt        <= cnt_n;
            bidx       <= bidx_n;
            shift      <= shift_n;
            o_tx       <= tx_n;
            o_busy     <= busy_n;
            o_grant_id <= grant_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: directed scenarios plus randomized traffic
// checked against a frame-level reference model of arbitration and 8N1 serialisation.
module tb_uart_tx_sched;

    localparam int CPB     = 4;
    localparam int CPB_BIG = 2500;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  valid;
    logic [31:0] data;
    logic [3:0]  ready;
    logic        tx, busy;
    logic [1:0]  gid;

    logic [3:0]  valid_b;
    logic [31:0] data_b;
    logic [3:0]  ready_b;
    logic        tx_b, busy_b;
    logic [1:0]  gid_b;

    int          checks = 0;
    int          errors = 0;
    int          m_ptr  = 0;
    logic [7:0]  bytes_q [4];

    always #5 clk = ~clk;

    uart_tx_sched #(.NUM_REQ(4), .CLKS_PER_BIT(CPB)) dut (
        .i_clk(clk), .i_rst(rst), .i_req_valid(valid), .i_req_data(data),
        .o_req_ready(ready), .o_tx(tx), .o_busy(busy), .o_grant_id(gid)
    );

    uart_tx_sched #(.NUM_REQ(4), .CLKS_PER_BIT(CPB_BIG)) dut_big (
        .i_clk(clk), .i_rst(rst), .i_req_valid(valid_b), .i_req_data(data_b),
        .o_req_ready(ready_b), .o_tx(tx_b), .o_busy(busy_b), .o_grant_id(gid_b)
    );

    // Frame bit n of an 8N1 frame: start 0, data LSB first, stop 1.
    function automatic logic frame_bit(input logic [7:0] b, input int n);
        if (n == 0) return 1'b0;
        if (n >= 9) return 1'b1;
        return b[n-1];
    endfunction

    function automatic int model_winner(input logic [3:0] mask, input int ptr);
        for (int i = 0; i < 4; i++) begin
            if (mask[(ptr + i) % 4]) return (ptr + i) % 4;
        end
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [7:0] b);
        data[8*k +: 8] = b;
        bytes_q[k]     = b;
        valid[k]       = 1'b1;
    endtask

    // Handshake now, then the whole 40-cycle frame, ending in the first IDLE cycle.
    task automatic do_frame(input int id, input logic [7:0] b,
                            input logic [3:0] clear_mask, input logic [3:0] pulse_mask);
        logic [3:0] exp_rdy;
        exp_rdy = 4'(1 << id);
        #1;
        checks++;
        if (ready !== exp_rdy) begin
            errors++;
            $display("FAIL hs_ready id=%0d actual=%b required=%b", id, ready, exp_rdy);
        end
        step();
        valid = valid & ~clear_mask;
        checks++;
        if (gid !== 2'(id)) begin
            errors++;
            $display("FAIL grant_id actual=%0d required=%0d", gid, id);
        end
        for (int c = 0; c < 10*CPB; c++) begin
            if (c == 10) valid = valid | pulse_mask;
            if (c == 30) valid = valid & ~pulse_mask;
            #1;
            checks++;
            if (tx !== frame_bit(b, c / CPB)) begin
                errors++;
                $display("FAIL tx id=%0d byte=%h cyc=%0d actual=%b required=%b",
                         id, b, c, tx, frame_bit(b, c / CPB));
            end
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL busy_in_frame cyc=%0d actual=%b required=1", c, busy);
            end
            checks++;
            if (ready !== 4'b0000) begin
                errors++;
                $display("FAIL ready_in_frame cyc=%0d actual=%b required=0000", c, ready);
            end
            step();
        end
        #1;
        checks++;
        if (busy !== 1'b0 || tx !== 1'b1) begin
            errors++;
            $display("FAIL frame_end busy=%b tx=%b required busy=0 tx=1", busy, tx);
        end
        m_ptr = (id + 1) % 4;
    endtask

    task automatic test_reset();
        rst = 1'b1; valid = 4'hF; data = 32'h4433_2211;
        valid_b = 4'h0; data_b = 32'h0;
        repeat (3) step();
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || gid !== 2'd0 || ready !== 4'b0) begin
            errors++;
            $display("FAIL reset_state tx=%b busy=%b gid=%0d ready=%b required 1/0/0/0000",
                     tx, busy, gid, ready);
        end
        checks++;
        if (tx_b !== 1'b1 || busy_b !== 1'b0 || ready_b !== 4'b0) begin
            errors++;
            $display("FAIL reset_state_big tx=%b busy=%b ready=%b", tx_b, busy_b, ready_b);
        end
        valid = 4'h0;
        rst   = 1'b0;
        m_ptr = 0;
        step();
    endtask

    task automatic test_round_robin();
        set_req(0, 8'h11); set_req(1, 8'h22); set_req(2, 8'h33); set_req(3, 8'h44);
        do_frame(0, 8'h11, 4'h0, 4'h0);
        do_frame(1, 8'h22, 4'h0, 4'h0);
        do_frame(2, 8'h33, 4'h0, 4'h0);
        do_frame(3, 8'h44, 4'h0, 4'h0);
        do_frame(0, 8'h11, 4'hF, 4'h0);
    endtask

    task automatic test_single_byte();
        set_req(0, 8'hA5);
        do_frame(0, 8'hA5, 4'b0001, 4'h0);
    endtask

    task automatic test_pointer_rotation();
        set_req(2, 8'h5C);
        do_frame(2, 8'h5C, 4'b0100, 4'h0);
        set_req(1, 8'hE1); set_req(3, 8'h3B);
        do_frame(3, 8'h3B, 4'b1000, 4'h0);
        do_frame(1, 8'hE1, 4'b0010, 4'h0);
    endtask

    task automatic test_valid_withdrawn();
        set_req(0, 8'h96);
        data[15:8] = 8'h7E;
        do_frame(0, 8'h96, 4'b0001, 4'b0010);
        for (int c = 0; c < 8; c++) begin
            checks++;
            if (ready !== 4'b0 || busy !== 1'b0 || tx !== 1'b1) begin
                errors++;
                $display("FAIL idle_after_withdraw cyc=%0d ready=%b busy=%b tx=%b", c, ready, busy, tx);
            end
            step();
        end
        // Pointer must still be 1: with 1 and 2 both valid, 1 wins.
        set_req(1, 8'h0F); set_req(2, 8'hF0);
        do_frame(1, 8'h0F, 4'b0010, 4'h0);
        do_frame(2, 8'hF0, 4'b0100, 4'h0);
    endtask

    task automatic test_reset_mid_frame();
        set_req(2, 8'hC3);
        #1;
        checks++;
        if (ready !== 4'b0100) begin
            errors++;
            $display("FAIL rst_frame_hs actual=%b required=0100", ready);
        end
        step();
        valid = 4'h0;
        repeat (17) step();
        checks++;
        if (tx !== frame_bit(8'hC3, 4)) begin
            errors++;
            $display("FAIL tx_before_rst actual=%b required=%b", tx, frame_bit(8'hC3, 4));
        end
        set_req(3, 8'h00);
        rst = 1'b1;
        #1;
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || ready !== 4'b0 || gid !== 2'd0) begin
            errors++;
            $display("FAIL rst_mid_frame tx=%b busy=%b ready=%b gid=%0d required 1/0/0000/0",
                     tx, busy, ready, gid);
        end
        step();
        checks++;
        if (ready !== 4'b0 || tx !== 1'b1) begin
            errors++;
            $display("FAIL rst_held ready=%b tx=%b required 0000/1", ready, tx);
        end
        rst   = 1'b0;
        m_ptr = 0;
        do_frame(3, 8'h00, 4'b1000, 4'h0);
    endtask

    task automatic test_random();
        int         w;
        logic [3:0] newm;
        for (int it = 0; it < 24; it++) begin
            newm = 4'($urandom_range(0, 15));
            if (valid == 4'h0 && newm == 4'h0) newm = 4'(1 << $urandom_range(0, 3));
            for (int k = 0; k < 4; k++) begin
                if (newm[k] && !valid[k]) set_req(k, 8'($urandom));
            end
            w = model_winner(valid, m_ptr);
            do_frame(w, bytes_q[w], 4'(1 << w), 4'h0);
        end
        for (int d = 0; d < 4; d++) begin
            if (valid != 4'h0) begin
                w = model_winner(valid, m_ptr);
                do_frame(w, bytes_q[w], 4'(1 << w), 4'h0);
            end
        end
    endtask

    task automatic test_max_divider();
        int bad;
        valid_b = 4'b0001;
        data_b  = 32'h0000_0055;
        #1;
        checks++;
        if (ready_b !== 4'b0001) begin
            errors++;
            $display("FAIL big_hs actual=%b required=0001", ready_b);
        end
        step();
        valid_b = 4'h0;
        for (int n = 0; n < 10; n++) begin
            bad = 0;
            for (int c = 0; c < CPB_BIG; c++) begin
                if (tx_b !== frame_bit(8'h55, n) || busy_b !== 1'b1) bad++;
                step();
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL big_bit n=%0d bad_cycles=%0d required=0 bit=%b",
                         n, bad, frame_bit(8'h55, n));
            end
        end
        checks++;
        if (busy_b !== 1'b0 || tx_b !== 1'b1 || gid_b !== 2'd0) begin
            errors++;
            $display("FAIL big_end busy=%b tx=%b gid=%0d required 0/1/0", busy_b, tx_b, gid_b);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_byte();
        test_pointer_rotation();
        test_valid_withdrawn();
        test_reset_mid_frame();
        test_random();
        test_max_divider();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
